// File: rtl/systolic_operand_feeder.sv
// -----------------------------------------------------------------------------
// systolic_operand_feeder
//
// Purpose:
//   Drives the west (A) and north (B) edges of an N x N PE_MAC systolic array
//   for one output tile. The tile runs through these states:
//     - CLEAR:  clear the PE accumulators.
//     - STREAM: accept K A/B beats over a valid/ready handshake.
//     - DRAIN:  inject zeros until every PE holds its final sum.
//     - DONE:   pulse done.
//   Lane i of each edge is delayed by i+1 register stages to form the
//   diagonal wavefront the array expects.
//
// Optional build macro:
//   FEEDER_PERF_CNT_EN - when defined, stall_cnt counts STREAM cycles with
//                        in_valid low (saturating, cleared in CLEAR).
//                        When undefined, stall_cnt is tied to zero.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   start         begin a tile (sampled only in IDLE)
//   k_len         reduction length, sampled with start, clamped to KMAX
//   in_valid      A/B beat valid
//   in_ready      high only in STREAM; beat accepted on in_valid && in_ready
//   in_a_data     A vector, lane i = bits [i*DW +: DW]
//   in_b_data     B vector, same packing
//   out_a_data    skewed A, lane i feeds array row i
//   out_b_data    skewed B, lane i feeds array column i
//   out_ce        clock enable to every PE (same as the skew shift enable)
//   out_load_acc  accumulator clear to every PE, high in CLEAR
//   busy          high in any state except IDLE
//   done          one-cycle pulse; array results valid from here until CLEAR
//   stall_cnt     stall cycle counter (see FEEDER_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module systolic_operand_feeder #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int KMAX = 256,
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a_data,
    input  logic [N*DW-1:0] in_b_data,
    output logic [N*DW-1:0] out_a_data,
    output logic [N*DW-1:0] out_b_data,
    output logic            out_ce,
    output logic            out_load_acc,
    output logic            busy,
    output logic            done,
    output logic [31:0]     stall_cnt
);

    // The last beat needs 2N+2 advances to land in PE(N-1,N-1): one at the
    // accepting edge plus 2N+1 zero advances supplied by DRAIN.
    localparam int DCW = $clog2(2 * N + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N);
    localparam logic [KW-1:0]  KMAX_K     = KW'(KMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  klen_q, klen_d;
    logic [KW-1:0]  beat_q, beat_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           advance;
    logic           accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        klen_d       = klen_q;
        beat_d       = beat_q;
        drain_d      = drain_q;
        advance      = 1'b0;
        accept       = 1'b0;
        in_ready     = 1'b0;
        out_load_acc = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    klen_d  = (k_len > KMAX_K) ? KMAX_K : k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Shift a zero through the skew on the same edge the PEs clear.
                advance      = 1'b1;
                out_load_acc = 1'b1;
                beat_d       = '0;
                drain_d      = '0;
                state_d      = (klen_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                // Ready is unconditional here; a missing beat simply freezes
                // the whole pipeline instead of inserting a bubble.
                in_ready = 1'b1;
                accept   = in_valid;
                advance  = in_valid;
                if (in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q + KW'(1) == klen_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                advance = 1'b1;
                drain_d = drain_q + DCW'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_ce = advance;

    // ------------------------------------------------------------------
    // Diagonal skew: lane gi is a (gi+1)-deep shift register per edge.
    // Stage 0 takes the accepted lane, or zero outside STREAM.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_sr_q [0:gi];
        logic [DW-1:0] b_sr_q [0:gi];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= gi; s++) begin
                    a_sr_q[s] <= '0;
                    b_sr_q[s] <= '0;
                end
            end else if (advance) begin
                a_sr_q[0] <= accept ? in_a_data[gi*DW +: DW] : '0;
                b_sr_q[0] <= accept ? in_b_data[gi*DW +: DW] : '0;
                for (int s = 1; s <= gi; s++) begin
                    a_sr_q[s] <= a_sr_q[s-1];
                    b_sr_q[s] <= b_sr_q[s-1];
                end
            end
        end

        assign out_a_data[gi*DW +: DW] = a_sr_q[gi];
        assign out_b_data[gi*DW +: DW] = b_sr_q[gi];
    end

    // ------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == S_CLEAR) begin
            stall_q <= '0;
        end else if ((state_q == S_STREAM) && !in_valid && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_operand_feeder. A small behavioural N x N PE_MAC
// array sits on the feeder outputs so final sums can be compared against
// hand-computed matrix products. Each PE does the following when out_ce is high:
//   - registers its A/B inputs,
//   - registers their product,
//   - accumulates, or clears the accumulator while out_load_acc is high.
// Cycle 0 of a tile is the cycle in which start is driven high.
// -----------------------------------------------------------------------------
module tb_systolic_operand_feeder;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int KMAX = 256;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int TMAX = 400;

`ifdef FEEDER_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd2;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a_data;
    logic [N*DW-1:0] in_b_data;
    logic [N*DW-1:0] out_a_data;
    logic [N*DW-1:0] out_b_data;
    logic            out_ce;
    logic            out_load_acc;
    logic            busy;
    logic            done;
    logic [31:0]     stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_operand_feeder #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .k_len        (k_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a_data    (in_a_data),
        .in_b_data    (in_b_data),
        .out_a_data   (out_a_data),
        .out_b_data   (out_b_data),
        .out_ce       (out_ce),
        .out_load_acc (out_load_acc),
        .busy         (busy),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    // ---------------- behavioural PE array ----------------
    logic signed [DW-1:0]   pa   [N][N];
    logic signed [DW-1:0]   pb   [N][N];
    logic signed [2*DW-1:0] pp   [N][N];
    logic signed [31:0]     pacc [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst_n) begin
                    pa[i][j]   <= '0;
                    pb[i][j]   <= '0;
                    pp[i][j]   <= '0;
                    pacc[i][j] <= '0;
                end else if (out_ce) begin
                    if (j == 0) pa[i][j] <= out_a_data[i*DW +: DW];
                    else        pa[i][j] <= pa[i][(j == 0) ? 0 : j-1];
                    if (i == 0) pb[i][j] <= out_b_data[j*DW +: DW];
                    else        pb[i][j] <= pb[(i == 0) ? 0 : i-1][j];
                    pp[i][j]   <= pa[i][j] * pb[i][j];
                    pacc[i][j] <= out_load_acc ? 32'sd0 : pacc[i][j] + pp[i][j];
                end
            end
        end
    end

    // ---------------- stimulus tables and traces ----------------
    logic [N*DW-1:0] a_tab [0:3];
    logic [N*DW-1:0] b_tab [0:3];

    logic            tr_ready [0:TMAX-1];
    logic            tr_ce    [0:TMAX-1];
    logic            tr_load  [0:TMAX-1];
    logic            tr_busy  [0:TMAX-1];
    logic [N*DW-1:0] tr_outa  [0:TMAX-1];
    logic [N*DW-1:0] tr_outb  [0:TMAX-1];
    logic [31:0]     tr_stall [0:TMAX-1];
    logic signed [31:0] acc_snap [N][N];
    int done_cyc;
    int accepts;

    // Runs one tile: start in cycle 0, in_valid low in cycles [slo..shi],
    // an extra start pulse in cycle 'again' (-1 for none). Records per-cycle
    // observations until the cycle after done, or TMAX cycles.
    task automatic run_tile(input int k, input int slo, input int shi, input int again);
        int bi;
        bi       = 0;
        done_cyc = -1;
        for (int c = 0; c < TMAX; c++) begin
            tr_ready[c] = 1'b0; tr_ce[c] = 1'b0; tr_load[c] = 1'b0;
            tr_busy[c]  = 1'b0; tr_outa[c] = '0; tr_outb[c] = '0; tr_stall[c] = '0;
        end
        for (int c = 0; c < TMAX; c++) begin
            start     = (c == 0) || (c == again);
            k_len     = KW'(k);
            in_valid  = !((c >= slo) && (c <= shi));
            in_a_data = (bi < 4) ? a_tab[bi] : '0;
            in_b_data = (bi < 4) ? b_tab[bi] : '0;
            @(negedge clk);
            tr_ready[c] = in_ready;
            tr_ce[c]    = out_ce;
            tr_load[c]  = out_load_acc;
            tr_busy[c]  = busy;
            tr_outa[c]  = out_a_data;
            tr_outb[c]  = out_b_data;
            tr_stall[c] = stall_cnt;
            if (done && done_cyc < 0) begin
                done_cyc = c;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc_snap[i][j] = pacc[i][j];
            end
            if (in_valid && in_ready) bi++;
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && c == done_cyc + 1) break;
        end
        accepts  = bi;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        k_len     = KW'(5);
        in_a_data = '1;
        in_b_data = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_ce, out_load_acc, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/ce/load/busy/done=%b want 00000",
                     {in_ready, out_ce, out_load_acc, busy, done});
        end
        n_checks++;
        if (out_a_data !== '0 || out_b_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h want 0", out_a_data, out_b_data);
        end
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    // Expected sums for the basic tables, row-major [i][j].
    function automatic int basic_exp(input int i, input int j);
        int t [16] = '{1, 0, 0, 2,  0, 1, 0, 0,  0, 0, 1, 0,  17, 34, 51, 34};
        return t[i*N + j];
    endfunction

    task automatic load_basic_tables();
        a_tab[0] = 32'h11000001; a_tab[1] = 32'h22000100;
        a_tab[2] = 32'h33010000; a_tab[3] = 32'h0;
        b_tab[0] = 32'h02000001; b_tab[1] = 32'h00000100;
        b_tab[2] = 32'h00010000; b_tab[3] = 32'h0;
    endtask

    task automatic test_basic();
        int ce_drain;
        load_basic_tables();
        run_tile(3, -1, -1, -1);
        n_checks++;
        if ({tr_load[0], tr_load[1], tr_load[2]} !== 3'b010) begin
            n_fail++;
            $display("FAIL basic_load: got load c0..c2=%b want 010", {tr_load[0], tr_load[1], tr_load[2]});
        end
        n_checks++;
        if ({tr_ready[1], tr_ready[2], tr_ready[3], tr_ready[4], tr_ready[5]} !== 5'b01110) begin
            n_fail++;
            $display("FAIL basic_ready: got ready c1..c5=%b want 01110",
                     {tr_ready[1], tr_ready[2], tr_ready[3], tr_ready[4], tr_ready[5]});
        end
        n_checks++;
        if (tr_outa[6][31:24] !== 8'h11 || tr_outa[8][31:24] !== 8'h33) begin
            n_fail++;
            $display("FAIL basic_skew: got lane3 c6=%h c8=%h want 11 33",
                     tr_outa[6][31:24], tr_outa[8][31:24]);
        end
        ce_drain = 0;
        for (int c = 5; c <= 13; c++) if (tr_ce[c]) ce_drain++;
        n_checks++;
        if (ce_drain !== 9 || tr_ce[14] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got ce count c5..c13=%0d ce c14=%b want 9 0", ce_drain, tr_ce[14]);
        end
        n_checks++;
        if (done_cyc !== 14 || tr_busy[14] !== 1'b1 || tr_busy[15] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done cycle %0d busy14=%b busy15=%b want 14 1 0",
                     done_cyc, tr_busy[14], tr_busy[15]);
        end
        n_checks++;
        if (tr_stall[14] !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_stall: got %0d want 0", tr_stall[14]);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (acc_snap[i][j] !== 32'(basic_exp(i, j))) begin
                    n_fail++;
                    $display("FAIL basic_acc[%0d][%0d]: got %0d want %0d", i, j, acc_snap[i][j], basic_exp(i, j));
                end
            end
        end
        $display("test_basic done: done cycle %0d", done_cyc);
    endtask

    task automatic test_stall();
        load_basic_tables();
        run_tile(3, 3, 4, -1);
        n_checks++;
        if (tr_ce[3] !== 1'b0 || tr_ce[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ce: got ce c3=%b c4=%b want 0 0", tr_ce[3], tr_ce[4]);
        end
        n_checks++;
        if (tr_outa[3] !== 32'h1 || tr_outa[4] !== 32'h1 || tr_outb[3] !== 32'h1 || tr_outb[4] !== 32'h1) begin
            n_fail++;
            $display("FAIL stall_hold: got a c3=%h c4=%h b c3=%h c4=%h want 00000001",
                     tr_outa[3], tr_outa[4], tr_outb[3], tr_outb[4]);
        end
        n_checks++;
        if (done_cyc !== 16) begin
            n_fail++;
            $display("FAIL stall_done: got done cycle %0d want 16", done_cyc);
        end
        n_checks++;
        if (tr_stall[16] !== EXP_STALL) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want %0d", tr_stall[16], EXP_STALL);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (acc_snap[i][j] !== 32'(basic_exp(i, j))) begin
                    n_fail++;
                    $display("FAIL stall_acc[%0d][%0d]: got %0d want %0d", i, j, acc_snap[i][j], basic_exp(i, j));
                end
            end
        end
        $display("test_stall done: done cycle %0d stall_cnt %0d", done_cyc, tr_stall[16]);
    endtask

    task automatic test_zero_len();
        int loads, readies;
        run_tile(0, -1, -1, -1);
        loads = 0; readies = 0;
        for (int c = 0; c < 4; c++) begin
            if (tr_load[c])  loads++;
            if (tr_ready[c]) readies++;
        end
        n_checks++;
        if (loads !== 1 || tr_load[1] !== 1'b1 || readies !== 0) begin
            n_fail++;
            $display("FAIL zero_ctrl: got loads=%0d load1=%b readies=%0d want 1 1 0", loads, tr_load[1], readies);
        end
        n_checks++;
        if (done_cyc !== 2) begin
            n_fail++;
            $display("FAIL zero_done: got done cycle %0d want 2", done_cyc);
        end
        n_checks++;
        if (acc_snap[3][3] !== 32'sd0 || acc_snap[0][0] !== 32'sd0) begin
            n_fail++;
            $display("FAIL zero_acc: got acc00=%0d acc33=%0d want 0 0", acc_snap[0][0], acc_snap[3][3]);
        end
        $display("test_zero_len done: done cycle %0d", done_cyc);
    endtask

    task automatic test_clamp_ignore();
        int busy_cnt;
        load_basic_tables();
        run_tile(300, -1, -1, 10);
        n_checks++;
        if (accepts !== 256) begin
            n_fail++;
            $display("FAIL clamp_beats: got %0d beats want 256", accepts);
        end
        n_checks++;
        if (done_cyc !== 267) begin
            n_fail++;
            $display("FAIL clamp_done: got done cycle %0d want 267", done_cyc);
        end
        busy_cnt = 0;
        for (int c = 0; c < TMAX; c++) if (tr_busy[c]) busy_cnt++;
        n_checks++;
        if (busy_cnt !== 267 || tr_busy[268] !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_busy: got busy cycles %0d busy268=%b want 267 0", busy_cnt, tr_busy[268]);
        end
        $display("test_clamp_ignore done: beats %0d done cycle %0d", accepts, done_cyc);
    endtask

    task automatic test_mid_reset();
        start     = 1'b1;
        k_len     = KW'(8);
        in_valid  = 1'b1;
        in_a_data = 32'h01020304;
        in_b_data = 32'h05060708;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_ce, out_load_acc, busy, done} !== 5'b0 || out_a_data !== '0 || out_b_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_idle: got ctrl=%b a=%h b=%h want 00000 0 0",
                     {in_ready, out_ce, out_load_acc, busy, done}, out_a_data, out_b_data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_tab[0] = 32'hFFFFFFFF; a_tab[1] = 32'h02020202; a_tab[2] = '0; a_tab[3] = '0;
        b_tab[0] = 32'h03030303; b_tab[1] = 32'h05050505; b_tab[2] = '0; b_tab[3] = '0;
        run_tile(2, -1, -1, -1);
        n_checks++;
        if (done_cyc !== 13) begin
            n_fail++;
            $display("FAIL midrst_done: got done cycle %0d want 13", done_cyc);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (acc_snap[i][j] !== 32'sd7) begin
                    n_fail++;
                    $display("FAIL midrst_acc[%0d][%0d]: got %0d want 7", i, j, acc_snap[i][j]);
                end
            end
        end
        $display("test_mid_reset done: done cycle %0d", done_cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        in_a_data = '0;
        in_b_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_clamp_ignore();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
